// File: rtl/cam_vga_top.sv
// Camera-to-VGA bridge: OV7670 RGB565 bytes into ping-pong line buffers,
// replayed on every row of a 640x480@60 raster from a single 50 MHz clock.
module cam_vga_top #(
   parameter int H_ACT   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_ACT   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33,
   parameter int LINE_W  = 640,
   parameter int LED_DIV = 24
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        cmos_pclk,
   input  logic        cmos_vsyn,
   input  logic        cmos_href,
   input  logic [7:0]  cmos_data,
   output logic        cmos_xclk,
   output logic        sclk,
   inout  wire         sda,
   output logic        VSYNC_Sig,
   output logic        HSYNC_Sig,
   output logic [4:0]  Red_Sig,
   output logic [5:0]  Green_Sig,
   output logic [4:0]  Blue_Sig,
   output logic        clk_100M,
   output logic        led_o1,
   output logic        led_o2,
   output logic        led_o3,
   output logic        sdram_clk,
   output logic        sdram_clke,
   output logic        sdram_ncs,
   output logic        sdram_nras,
   output logic        sdram_ncas,
   output logic        sdram_nwe,
   output logic [12:0] sdram_addr,
   output logic [1:0]  sdram_ba,
   output logic [1:0]  sdram_dqm,
   inout  wire  [15:0] sdram_data
);

   localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int AW    = $clog2(LINE_W + 1);

   localparam logic [HW-1:0] H_MAX = HW'(H_TOT - 1);
   localparam logic [HW-1:0] H_A   = HW'(H_ACT);
   localparam logic [HW-1:0] HS_B  = HW'(H_ACT + H_FP);
   localparam logic [HW-1:0] HS_E  = HW'(H_ACT + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_MAX = VW'(V_TOT - 1);
   localparam logic [VW-1:0] V_A   = VW'(V_ACT);
   localparam logic [VW-1:0] VS_B  = VW'(V_ACT + V_FP);
   localparam logic [VW-1:0] VS_E  = VW'(V_ACT + V_FP + V_SYNC - 1);
   localparam logic [AW-1:0] W_MAX = AW'(LINE_W);

   // board-compatibility tie-offs
   assign sclk        = 1'b1;
   assign sda         = 1'bz;
   assign sdram_clk   = ~CLK;
   assign sdram_clke  = 1'b1;
   assign sdram_ncs   = 1'b1;
   assign sdram_nras  = 1'b1;
   assign sdram_ncas  = 1'b1;
   assign sdram_nwe   = 1'b1;
   assign sdram_addr  = '0;
   assign sdram_ba    = '0;
   assign sdram_dqm   = 2'b11;
   assign sdram_data  = 'z;

   logic [1:0]         xclk_cnt;
   logic [LED_DIV-1:0] led_cnt;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         xclk_cnt <= '0;
         led_cnt  <= '0;
      end else begin
         xclk_cnt <= xclk_cnt + 2'd1;
         led_cnt  <= led_cnt + 1'b1;
      end
   end

   assign cmos_xclk = xclk_cnt[1];
   assign led_o1    = led_cnt[LED_DIV-1];

   logic [2:0] pclk_sr;
   logic [2:0] vsyn_sr;
   logic [2:0] href_sr;
   logic [7:0] data_s1;
   logic [7:0] data_s2;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         pclk_sr <= '0;
         vsyn_sr <= '0;
         href_sr <= '0;
         data_s1 <= '0;
         data_s2 <= '0;
      end else begin
         pclk_sr <= {pclk_sr[1:0], cmos_pclk};
         vsyn_sr <= {vsyn_sr[1:0], cmos_vsyn};
         href_sr <= {href_sr[1:0], cmos_href};
         data_s1 <= cmos_data;
         data_s2 <= data_s1;
      end
   end

   logic pclk_rise;
   logic href_fall;
   logic vsyn_rise;
   logic cap;

   assign pclk_rise = pclk_sr[1] & ~pclk_sr[2];
   assign href_fall = ~href_sr[1] & href_sr[2];
   assign vsyn_rise = vsyn_sr[1] & ~vsyn_sr[2];
   assign cap       = pclk_rise & href_sr[1] & ~vsyn_sr[1];

   logic          phase;
   logic [7:0]    hi_byte;
   logic [AW-1:0] wptr;
   logic          wbuf_sel;
   logic          rbuf_sel;
   logic [AW-1:0] rlen;
   logic          ready;
   logic          led2;
   logic          led3;
   logic          wr_en;

   assign wr_en = cap & phase & (wptr < W_MAX);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         phase    <= 1'b0;
         hi_byte  <= '0;
         wptr     <= '0;
         wbuf_sel <= 1'b0;
         rbuf_sel <= 1'b0;
         rlen     <= '0;
         ready    <= 1'b0;
         led3     <= 1'b0;
      end else if (href_fall) begin
         // publish the finished line and flip capture to the other buffer
         if (wptr != '0) begin
            rbuf_sel <= wbuf_sel;
            rlen     <= wptr;
            wbuf_sel <= ~wbuf_sel;
            ready    <= 1'b1;
            led3     <= ~led3;
         end
         wptr  <= '0;
         phase <= 1'b0;
      end else if (vsyn_sr[1]) begin
         wptr  <= '0;
         phase <= 1'b0;
      end else if (cap) begin
         phase <= ~phase;
         if (!phase) begin
            hi_byte <= data_s2;
         end else if (wptr < W_MAX) begin
            wptr <= wptr + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         led2 <= 1'b0;
      end else if (vsyn_rise) begin
         led2 <= 1'b1;
      end
   end

   assign led_o2 = led2;
   assign led_o3 = led3;

   logic [15:0] mem0 [LINE_W];
   logic [15:0] mem1 [LINE_W];

   always_ff @(posedge CLK) begin
      if (wr_en && !wbuf_sel) begin
         mem0[wptr] <= {hi_byte, data_s2};
      end
      if (wr_en && wbuf_sel) begin
         mem1[wptr] <= {hi_byte, data_s2};
      end
   end

   logic          pe;
   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic          h_wrap;
   logic          rsel;
   logic [AW-1:0] rlen_l;
   logic          rdy_l;
   logic [AW-1:0] raddr;
   logic [15:0]   ram_q;
   logic          act;
   logic          show;
   logic          hs_d;
   logic          vs_d;
   logic          show_d;
   logic          white_d;

   assign h_wrap = (hcnt == H_MAX);
   assign raddr  = (hcnt < H_A) ? AW'(hcnt) : '0;
   assign act    = (hcnt < H_A) && (vcnt < V_A);
   assign show   = act && rdy_l && (32'(hcnt) < 32'(rlen_l));

   always_ff @(posedge CLK) begin
      if (pe) begin
         ram_q <= rsel ? mem1[raddr] : mem0[raddr];
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         pe      <= 1'b0;
         hcnt    <= '0;
         vcnt    <= '0;
         rsel    <= 1'b0;
         rlen_l  <= '0;
         rdy_l   <= 1'b0;
         hs_d    <= 1'b1;
         vs_d    <= 1'b1;
         show_d  <= 1'b0;
         white_d <= 1'b0;
      end else begin
         pe <= ~pe;
         if (pe) begin
            hcnt <= h_wrap ? '0 : hcnt + 1'b1;
            // buffer choice frozen per VGA line so a camera swap never tears it
            if (h_wrap) begin
               vcnt   <= (vcnt == V_MAX) ? '0 : vcnt + 1'b1;
               rsel   <= rbuf_sel;
               rlen_l <= rlen;
               rdy_l  <= ready;
            end
            hs_d    <= !((hcnt >= HS_B) && (hcnt <= HS_E));
            vs_d    <= !((vcnt >= VS_B) && (vcnt <= VS_E));
            show_d  <= show;
            white_d <= act && !show;
         end
      end
   end

   logic [15:0] rgb;

   always_comb begin
      rgb = 16'h0000;
      if (show_d) begin
         rgb = ram_q;
      end else if (white_d) begin
         rgb = 16'hFFFF;
      end
   end

   assign Red_Sig   = rgb[15:11];
   assign Green_Sig = rgb[10:5];
   assign Blue_Sig  = rgb[4:0];
   assign HSYNC_Sig = hs_d;
   assign VSYNC_Sig = vs_d;
   assign clk_100M  = pe;

endmodule

// File: tb/tb_cam_vga_top.sv
// Directed bench for cam_vga_top with a shortened 8-line vertical frame;
// pixel P of the raster appears on the outputs from CLK edge 2P+2 after reset.
module tb_cam_vga_top;

   logic       CLK = 1'b0;
   logic       RSTn = 1'b1;
   logic       cmos_pclk = 1'b0;
   logic       cmos_vsyn = 1'b0;
   logic       cmos_href = 1'b0;
   logic [7:0] cmos_data = 8'h00;

   logic        cmos_xclk, sclk, VSYNC_Sig, HSYNC_Sig, clk_100M;
   logic [4:0]  Red_Sig, Blue_Sig;
   logic [5:0]  Green_Sig;
   logic        led_o1, led_o2, led_o3;
   logic        sdram_clk, sdram_clke, sdram_ncs, sdram_nras;
   logic        sdram_ncas, sdram_nwe;
   logic [12:0] sdram_addr;
   logic [1:0]  sdram_ba, sdram_dqm;
   wire         sda;
   wire  [15:0] sdram_data;

   cam_vga_top #(
      .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut (
      .CLK(CLK), .RSTn(RSTn),
      .cmos_pclk(cmos_pclk), .cmos_vsyn(cmos_vsyn),
      .cmos_href(cmos_href), .cmos_data(cmos_data),
      .cmos_xclk(cmos_xclk), .sclk(sclk), .sda(sda),
      .VSYNC_Sig(VSYNC_Sig), .HSYNC_Sig(HSYNC_Sig),
      .Red_Sig(Red_Sig), .Green_Sig(Green_Sig), .Blue_Sig(Blue_Sig),
      .clk_100M(clk_100M),
      .led_o1(led_o1), .led_o2(led_o2), .led_o3(led_o3),
      .sdram_clk(sdram_clk), .sdram_clke(sdram_clke),
      .sdram_ncs(sdram_ncs), .sdram_nras(sdram_nras),
      .sdram_ncas(sdram_ncas), .sdram_nwe(sdram_nwe),
      .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
      .sdram_dqm(sdram_dqm), .sdram_data(sdram_data)
   );

   always #10 CLK = ~CLK;

   int cyc;
   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) cyc <= 0;
      else cyc <= cyc + 1;
   end

   int errs = 0;
   int checks = 0;
   wire [15:0] rgb = {Red_Sig, Green_Sig, Blue_Sig};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge CLK);
   endtask

   task automatic px(input string tag, input int l, input int x,
                     input logic [15:0] exp);
      wait_cyc(2 * (l * 800 + x) + 2);
      chk(tag, rgb, exp);
   endtask

   function automatic int next_line(input int c);
      int l;
      l = (c + 16) / 1600 + 1;
      while (l % 8 >= 4) l++;
      return l;
   endfunction

   function automatic logic [15:0] pix(input int kind, input int i);
      logic [15:0] v;
      v = 16'(i);
      case (kind)
         1: v = 16'hA53C;
         2: v = 16'h8000 | 16'(i);
         3: v = 16'h4000 | 16'(i);
         default: v = 16'(i);
      endcase
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      cmos_pclk = 1'b0;
      cmos_data = b;
      cmos_href = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      cmos_pclk = 1'b1;
      @(negedge CLK);
   endtask

   task automatic cam_line(input int n, input int kind);
      logic [15:0] p;
      for (int i = 0; i < n; i++) begin
         p = pix(kind, i);
         send_byte(p[15:8]);
         send_byte(p[7:0]);
      end
      @(negedge CLK);
      cmos_pclk = 1'b0;
      cmos_href = 1'b0;
      repeat (8) @(negedge CLK);
   endtask

   int l;

   initial begin
      #2 RSTn = 1'b0;
      #3;
      chk("rst_vs", VSYNC_Sig, 1);
      chk("rst_hs", HSYNC_Sig, 1);
      chk("rst_rgb", rgb, 0);
      chk("rst_leds", {led_o1, led_o2, led_o3}, 0);
      chk("rst_xclk", cmos_xclk, 0);
      chk("rst_pe", clk_100M, 0);
      chk("sdram_park", {sdram_clke, sdram_ncs, sdram_nras, sdram_ncas,
                         sdram_nwe, sdram_dqm}, 7'b1111111);
      repeat (3) @(negedge CLK);
      RSTn = 1'b1;

      wait_cyc(1);
      chk("pe_on", clk_100M, 1);
      wait_cyc(2);
      chk("xclk_hi", cmos_xclk, 1);
      px("idle_x0", 0, 0, 16'hFFFF);
      px("idle_x639", 0, 639, 16'hFFFF);
      px("hblank_x640", 0, 640, 16'h0000);
      wait_cyc(1313);
      chk("hs_pre", HSYNC_Sig, 1);
      wait_cyc(1314);
      chk("hs_fall", HSYNC_Sig, 0);
      wait_cyc(1505);
      chk("hs_last", HSYNC_Sig, 0);
      wait_cyc(1506);
      chk("hs_rise", HSYNC_Sig, 1);
      wait_cyc(2913);
      chk("hs_pre2", HSYNC_Sig, 1);
      wait_cyc(2914);
      chk("hs_period", HSYNC_Sig, 0);
      px("idle_l3", 3, 100, 16'hFFFF);
      px("vblank_l4", 4, 10, 16'h0000);
      wait_cyc(8001);
      chk("vs_pre", VSYNC_Sig, 1);
      wait_cyc(8002);
      chk("vs_fall", VSYNC_Sig, 0);
      wait_cyc(11201);
      chk("vs_last", VSYNC_Sig, 0);
      wait_cyc(11202);
      chk("vs_rise", VSYNC_Sig, 1);
      wait_cyc(20801);
      chk("vs_pre2", VSYNC_Sig, 1);
      wait_cyc(20802);
      chk("vs_frame", VSYNC_Sig, 0);
      chk("led2_idle", led_o2, 0);

      @(negedge CLK);
      cmos_vsyn = 1'b1;
      repeat (16) @(negedge CLK);
      cmos_vsyn = 1'b0;
      repeat (4) @(negedge CLK);
      chk("led2_set", led_o2, 1);

      cam_line(640, 0);
      chk("led3_a", led_o3, 1);
      l = next_line(cyc);
      px("full_x0", l, 0, 16'h0000);
      px("full_x1", l, 1, 16'h0001);
      px("full_x320", l, 320, 16'h0140);
      px("full_x639", l, 639, 16'h027F);
      px("full_x640", l, 640, 16'h0000);

      cam_line(1, 1);
      chk("led3_b", led_o3, 0);
      l = next_line(cyc);
      px("a53c_px", l, 0, 16'hA53C);
      chk("a53c_r", Red_Sig, 5'h14);
      chk("a53c_g", Green_Sig, 6'h29);
      chk("a53c_b", Blue_Sig, 5'h1C);
      px("a53c_x1", l, 1, 16'hFFFF);

      cam_line(100, 0);
      chk("led3_c", led_o3, 1);
      l = next_line(cyc);
      px("short_x0", l, 0, 16'h0000);
      px("short_x99", l, 99, 16'h0063);
      px("short_x100", l, 100, 16'hFFFF);
      px("short_x639", l, 639, 16'hFFFF);

      cam_line(800, 0);
      chk("led3_d", led_o3, 0);
      l = next_line(cyc);
      px("long_x0", l, 0, 16'h0000);
      px("long_x159", l, 159, 16'h009F);
      px("long_x639", l, 639, 16'h027F);

      cam_line(20, 2);
      chk("led3_e", led_o3, 1);
      l = next_line(cyc);
      px("pp_a_x5", l, 5, 16'h8005);
      px("pp_a_x20", l, 20, 16'hFFFF);
      cam_line(20, 3);
      chk("led3_f", led_o3, 0);
      l = next_line(cyc);
      px("pp_b_x5", l, 5, 16'h4005);
      px("pp_b_x19", l, 19, 16'h4013);

      RSTn = 1'b0;
      #1;
      chk("mid_rgb", rgb, 0);
      chk("mid_hs", HSYNC_Sig, 1);
      chk("mid_vs", VSYNC_Sig, 1);
      chk("mid_leds", {led_o1, led_o2, led_o3}, 0);
      chk("mid_xclk", cmos_xclk, 0);
      chk("mid_pe", clk_100M, 0);
      @(negedge CLK);
      RSTn = 1'b1;
      px("post_rst_x5", 0, 5, 16'hFFFF);
      px("post_rst_x0", 0, 0 + 6, 16'hFFFF);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
